// File: rtl/lut_config_loader.sv
// Serial LUT configuration loader: shifts MEM_SIZE-bit frames in, then
// pulses a one-hot per-LUT enable to latch each frame into NUM_LUTS blocks.
// Ports: cclk, rst_n (async, active-low), start, bit_in, bit_valid,
//   bit_ready, config_out[MEM_SIZE], cen_out[NUM_LUTS], busy, done, error.
// Option: LUT_CONFIG_PARITY_EN adds an even-parity bit per frame
//   and a sticky error flag; otherwise error is tied 0.
module lut_config_loader #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int NUM_LUTS  = 4
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic [MEM_SIZE-1:0] config_out,
  output logic [NUM_LUTS-1:0] cen_out,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam int IW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
`ifdef LUT_CONFIG_PARITY_EN
    ST_PARITY = 3'd2,
`endif
    ST_COMMIT = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [MEM_SIZE-1:0] r_frame;
  logic [MEM_SIZE-1:0] w_frame_nxt;
  logic                w_accept;
  logic                w_last_bit;
  logic                w_last_lut;
  logic                w_advance;

  assign w_accept   = bit_valid & bit_ready;
  assign w_last_bit = (r_cnt == CW'(MEM_SIZE - 1));
  assign w_last_lut = (r_idx == IW'(NUM_LUTS - 1));

`ifdef LUT_CONFIG_PARITY_EN
  logic r_err;
  logic w_par_ok;
  // Even parity: the parity bit equals the XOR of the frame.
  assign w_par_ok  = (bit_in == ^r_frame);
  // A failed frame moves on to the next LUT without a commit.
  assign w_advance = (r_state == ST_COMMIT) |
                     ((r_state == ST_PARITY) & w_accept & ~w_par_ok);
  assign error     = r_err;
`else
  assign w_advance = (r_state == ST_COMMIT);
  assign error     = 1'b0;
`endif

  // Write the incoming bit at index r_cnt.
  always_comb begin
    w_frame_nxt = r_frame;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (r_cnt == CW'(i)) w_frame_nxt[i] = bit_in;
    end
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    bit_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cen_out   = '0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_ready = 1'b1;
        if (w_accept && w_last_bit) begin
`ifdef LUT_CONFIG_PARITY_EN
          w_nxt = ST_PARITY;
`else
          w_nxt = ST_COMMIT;
`endif
        end
      end
`ifdef LUT_CONFIG_PARITY_EN
      ST_PARITY: begin
        bit_ready = 1'b1;
        if (w_accept) begin
          if (w_par_ok)        w_nxt = ST_COMMIT;
          else if (w_last_lut) w_nxt = ST_FINISH;
          else                 w_nxt = ST_SHIFT;
        end
      end
`endif
      ST_COMMIT: begin
        cen_out = NUM_LUTS'(1) << r_idx;
        w_nxt   = w_last_lut ? ST_FINISH : ST_SHIFT;
      end
      ST_FINISH: begin
        done  = 1'b1;
        w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_cnt <= '0;
        r_idx <= '0;
      end
      if (r_state == ST_SHIFT && w_accept) begin
        r_frame <= w_frame_nxt;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_advance && !w_last_lut) begin
        r_idx <= r_idx + IW'(1);
        r_cnt <= '0;
      end
    end
  end

`ifdef LUT_CONFIG_PARITY_EN
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n)                           r_err <= 1'b0;
    else if (r_state == ST_IDLE && start) r_err <= 1'b0;
    else if (r_state == ST_PARITY && w_accept && !w_par_ok)
      r_err <= 1'b1;
  end
`endif

  assign config_out = r_frame;

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader (default parameters).
// Expected LUT commits are queued at stimulus time and popped on cen_out.
module tb_lut_config_loader;

`ifdef LUT_CONFIG_PARITY_EN
  localparam int FB = 17;
`else
  localparam int FB = 16;
`endif

  logic        cclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [15:0] config_out;
  logic [3:0]  cen_out;
  logic        busy;
  logic        done;
  logic        error;

  lut_config_loader dut (
    .cclk       (cclk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .config_out (config_out),
    .cen_out    (cen_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    logic [3:0]  cen;
    logic [15:0] frame;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [15:0] fr [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_cen_cyc = -100;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge cclk) cyc++;

  always @(negedge cclk) begin
    if (rst_n) begin
      if (cen_out != 4'b0) begin
        chk("cen_onehot", 32'($countones(cen_out)), 32'd1);
        if (sbq.size() == 0) begin
          chk("cen_unexpected", {28'd0, cen_out}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("cen_order", {28'd0, cen_out}, {28'd0, e.cen});
          chk("frame", {16'd0, config_out}, {16'd0, e.frame});
        end
        if (cen_out[3]) last_cen_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_lat", 32'(cyc - last_cen_cyc), 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic push(input int lut, input logic [15:0] f);
    exp_t x;
    x.cen   = 4'b0001 << lut;
    x.frame = f;
    sbq.push_back(x);
  endtask

  task automatic send_bits(input logic [15:0] f, input int nbits,
                           input bit rnd, input int start_at,
                           input bit bad_par);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < nbits) begin
      bit_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_in    = (k < 16) ? f[k] : ((^f) ^ bad_par);
      start     = (k == start_at);
      #1;
      acc = bit_valid && bit_ready;
      @(posedge cclk);
      #1;
      if (acc) k++;
      guard++;
      if (guard > 1000) begin
        chk("bit_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(posedge cclk);
    #1;
    start = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int i;
    for (i = 0; i < 200; i++) begin
      if (done_cnt > d0) break;
      @(posedge cclk);
      #1;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic run_session(input bit rnd, input int sh_lut,
                             input int sh_bit);
    begin_session();
    for (int l = 0; l < 4; l++) push(l, fr[l]);
    for (int l = 0; l < 4; l++)
      send_bits(fr[l], FB, rnd, (l == sh_lut) ? sh_bit : -1, 1'b0);
    wait_done();
    chk("hold_frame", {16'd0, config_out}, {16'd0, fr[3]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge cclk);
    #1;
    chk("rst_cfg", {16'd0, config_out}, 32'd0);
    chk("rst_cen", {28'd0, cen_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, bit_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    @(posedge cclk);
    #1;
    chk("idle_ready", {31'd0, bit_ready}, 32'd0);

    fr[0] = 16'hA5C3; fr[1] = 16'h1234;
    fr[2] = 16'hFFFF; fr[3] = 16'h0001;
    run_session(1'b0, -1, -1);
    chk("err_clean", {31'd0, error}, 32'd0);

    fr[0] = 16'h5A3C; fr[1] = 16'h8001;
    fr[2] = 16'h0000; fr[3] = 16'hC0DE;
    run_session(1'b1, -1, -1);

    fr[0] = 16'h1111; fr[1] = 16'hBEEF;
    fr[2] = 16'h7E81; fr[3] = 16'h4242;
    run_session(1'b0, 1, 5);

    fr[0] = 16'hDEAD; fr[1] = 16'h0F0F;
    fr[2] = 16'hFFFF; fr[3] = 16'h9999;
    begin_session();
    push(0, fr[0]);
    push(1, fr[1]);
    send_bits(fr[0], FB, 1'b0, -1, 1'b0);
    send_bits(fr[1], FB, 1'b0, -1, 1'b0);
    send_bits(fr[2], 9, 1'b0, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cfg", {16'd0, config_out}, 32'd0);
    chk("mid_rst_cen", {28'd0, cen_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bit_ready}, 32'd0);
    chk("mid_rst_sb", 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (2) @(posedge cclk);
    #1;
    rst_n = 1'b1;
    @(posedge cclk);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_session(1'b0, -1, -1);

`ifdef LUT_CONFIG_PARITY_EN
    begin_session();
    push(1, 16'h0003);
    push(2, 16'h00F0);
    push(3, 16'h8421);
    send_bits(16'h0001, FB, 1'b0, -1, 1'b1);
    chk("par_err_set", {31'd0, error}, 32'd1);
    send_bits(16'h0003, FB, 1'b0, -1, 1'b0);
    send_bits(16'h00F0, FB, 1'b0, -1, 1'b0);
    send_bits(16'h8421, FB, 1'b0, -1, 1'b0);
    wait_done();
    chk("par_err_sticky", {31'd0, error}, 32'd1);
    fr[0] = 16'h1357; fr[1] = 16'h2468;
    fr[2] = 16'hAAAA; fr[3] = 16'h5555;
    run_session(1'b0, -1, -1);
    chk("par_err_clr", {31'd0, error}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
